// File: rtl/parking_gate_arbiter.sv
// Shared barrier-gate controller for a single-gate car park: entry passcode check,
// gate dwell timing, wrong-code lockout and occupancy tracking against capacity.
module parking_gate_arbiter #(
  parameter int         CAPACITY    = 8,
  parameter logic [3:0] PASS_CODE   = 4'b1011,
  parameter int         WAIT_CYCLES = 16,
  parameter int         GATE_CYCLES = 8,
  parameter int         MAX_TRIES   = 3,
  parameter int         LOCK_CYCLES = 32,
  localparam int        CW          = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sensor_entrance,
  input  logic          sensor_exit,
  input  logic [3:0]    password,
  input  logic          pass_valid,
  output logic          gate_open,
  output logic          green_led,
  output logic          red_led,
  output logic          alarm,
  output logic [CW-1:0] occupancy,
  output logic          full
);

  localparam int TMAX_AB = (WAIT_CYCLES > GATE_CYCLES) ? WAIT_CYCLES : GATE_CYCLES;
  localparam int TMAX    = (TMAX_AB > LOCK_CYCLES) ? TMAX_AB : LOCK_CYCLES;
  localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int NW      = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHECK      = 3'd1,
    ENTER_OPEN = 3'd2,
    EXIT_OPEN  = 3'd3,
    LOCKOUT    = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [NW-1:0] tries_reg, tries_next;
  logic [CW-1:0] occ_reg, occ_next;
  logic          full_flag;

  assign full_flag = (occ_reg == CW'(CAPACITY));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      tries_reg <= '0;
      occ_reg   <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      tries_reg <= tries_next;
      occ_reg   <= occ_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    tries_next = tries_reg;
    occ_next   = occ_reg;
    case (state_reg)
      IDLE: begin
        // Exit wins a simultaneous request so a full park can always drain.
        if (sensor_exit && (occ_reg != '0)) begin
          state_next = EXIT_OPEN;
          timer_next = TW'(GATE_CYCLES - 1);
        end else if (sensor_entrance && !full_flag) begin
          state_next = CHECK;
          timer_next = TW'(WAIT_CYCLES - 1);
          tries_next = '0;
        end
      end
      CHECK: begin
        if (pass_valid) begin
          if (password == PASS_CODE) begin
            state_next = ENTER_OPEN;
            timer_next = TW'(GATE_CYCLES - 1);
          end else if ((tries_reg + NW'(1)) == NW'(MAX_TRIES)) begin
            state_next = LOCKOUT;
            timer_next = TW'(LOCK_CYCLES - 1);
          end else begin
            tries_next = tries_reg + NW'(1);
            timer_next = TW'(WAIT_CYCLES - 1);
          end
        end else if (timer_reg == '0) begin
          state_next = IDLE;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      ENTER_OPEN: begin
        // Timer parks at zero; the gate stays up while a car is under it.
        if (timer_reg != '0) begin
          timer_next = timer_reg - TW'(1);
        end else if (!sensor_entrance) begin
          state_next = IDLE;
          occ_next   = occ_reg + CW'(1);
        end
      end
      EXIT_OPEN: begin
        if (timer_reg != '0) begin
          timer_next = timer_reg - TW'(1);
        end else if (!sensor_exit) begin
          state_next = IDLE;
          occ_next   = occ_reg - CW'(1);
        end
      end
      LOCKOUT: begin
        if (timer_reg == '0) begin
          state_next = IDLE;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gate_open = 1'b0;
    green_led = 1'b0;
    red_led   = 1'b0;
    alarm     = 1'b0;
    case (state_reg)
      CHECK: red_led = 1'b1;
      ENTER_OPEN, EXIT_OPEN: begin
        gate_open = 1'b1;
        green_led = 1'b1;
      end
      LOCKOUT: begin
        red_led = 1'b1;
        alarm   = 1'b1;
      end
      default: ;
    endcase
  end

  assign occupancy = occ_reg;
  assign full      = full_flag;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: reset, entry, timeout, lockout,
// exit priority, full gating and asynchronous mid-operation reset.
module tb_parking_gate_arbiter;

  localparam logic [3:0] GOOD = 4'b1011;
  localparam logic [3:0] BAD  = 4'b0000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sensor_entrance = 1'b0;
  logic       sensor_exit = 1'b0;
  logic [3:0] password = 4'b0000;
  logic       pass_valid = 1'b0;
  logic       gate_open, green_led, red_led, alarm, full;
  logic [3:0] occupancy;

  int compared = 0;
  int mismatched = 0;

  parking_gate_arbiter dut (
    .clk(clk), .rst(rst),
    .sensor_entrance(sensor_entrance), .sensor_exit(sensor_exit),
    .password(password), .pass_valid(pass_valid),
    .gate_open(gate_open), .green_led(green_led), .red_led(red_led),
    .alarm(alarm), .occupancy(occupancy), .full(full)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs set afterwards are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: a full successful entry, ending back in IDLE.
  task automatic enter_car();
    sensor_entrance = 1'b1;
    step();
    sensor_entrance = 1'b0;
    password = GOOD;
    pass_valid = 1'b1;
    step();
    pass_valid = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    compared++;
    if ({gate_open, green_led, red_led, alarm, full} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b want 00000", {gate_open, green_led, red_led, alarm, full});
    end
    compared++;
    if (occupancy !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_occupancy: got %0d want 0", occupancy);
    end
    $display("reset: outputs=%b occupancy=%0d", {gate_open, green_led, red_led, alarm, full}, occupancy);
  endtask

  task automatic test_good_entry();
    sensor_entrance = 1'b1;
    step();
    sensor_entrance = 1'b0;
    compared++;
    if (red_led !== 1'b1 || gate_open !== 1'b0) begin
      mismatched++;
      $display("FAIL entry_check_red: red=%b gate=%b want red=1 gate=0", red_led, gate_open);
    end
    password = GOOD;
    pass_valid = 1'b1;
    step();
    pass_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (gate_open !== 1'b1 || green_led !== 1'b1 || red_led !== 1'b0) begin
        mismatched++;
        $display("FAIL entry_gate_cycle%0d: gate=%b green=%b red=%b want 1 1 0", i, gate_open, green_led, red_led);
      end
      step();
    end
    compared++;
    if (gate_open !== 1'b0 || green_led !== 1'b0 || occupancy !== 4'd1) begin
      mismatched++;
      $display("FAIL entry_done: gate=%b green=%b occ=%0d want 0 0 1", gate_open, green_led, occupancy);
    end
    $display("good_entry: occupancy=%0d", occupancy);
  endtask

  task automatic test_timeout();
    sensor_entrance = 1'b1;
    step();
    sensor_entrance = 1'b0;
    for (int i = 0; i < 16; i++) begin
      compared++;
      if (red_led !== 1'b1) begin
        mismatched++;
        $display("FAIL timeout_wait_cycle%0d: red=%b want 1", i, red_led);
      end
      step();
    end
    compared++;
    if (red_led !== 1'b0 || gate_open !== 1'b0 || occupancy !== 4'd1) begin
      mismatched++;
      $display("FAIL timeout_idle: red=%b gate=%b occ=%0d want 0 0 1", red_led, gate_open, occupancy);
    end
    $display("timeout: red=%b occupancy=%0d", red_led, occupancy);
  endtask

  task automatic test_lockout();
    sensor_entrance = 1'b1;
    step();
    sensor_entrance = 1'b0;
    for (int t = 0; t < 3; t++) begin
      password = BAD;
      pass_valid = 1'b1;
      step();
      pass_valid = 1'b0;
      if (t < 2) begin
        compared++;
        if (red_led !== 1'b1 || alarm !== 1'b0) begin
          mismatched++;
          $display("FAIL lockout_try%0d: red=%b alarm=%b want 1 0", t, red_led, alarm);
        end
        step();
      end
    end
    for (int i = 0; i < 32; i++) begin
      compared++;
      if (alarm !== 1'b1 || red_led !== 1'b1 || gate_open !== 1'b0) begin
        mismatched++;
        $display("FAIL lockout_cycle%0d: alarm=%b red=%b gate=%b want 1 1 0", i, alarm, red_led, gate_open);
      end
      password = GOOD;
      pass_valid = (i == 5);
      step();
      pass_valid = 1'b0;
    end
    compared++;
    if (alarm !== 1'b0 || red_led !== 1'b0 || gate_open !== 1'b0 || occupancy !== 4'd1) begin
      mismatched++;
      $display("FAIL lockout_end: alarm=%b red=%b gate=%b occ=%0d want 0 0 0 1", alarm, red_led, gate_open, occupancy);
    end
    $display("lockout: alarm=%b occupancy=%0d", alarm, occupancy);
  endtask

  task automatic test_exit_priority();
    enter_car();
    compared++;
    if (occupancy !== 4'd2) begin
      mismatched++;
      $display("FAIL priority_setup: occ=%0d want 2", occupancy);
    end
    sensor_entrance = 1'b1;
    sensor_exit = 1'b1;
    step();
    sensor_entrance = 1'b0;
    sensor_exit = 1'b0;
    compared++;
    if (gate_open !== 1'b1 || red_led !== 1'b0) begin
      mismatched++;
      $display("FAIL priority_exit_first: gate=%b red=%b want 1 0", gate_open, red_led);
    end
    repeat (8) step();
    compared++;
    if (occupancy !== 4'd1 || gate_open !== 1'b0) begin
      mismatched++;
      $display("FAIL priority_exit_done: occ=%0d gate=%b want 1 0", occupancy, gate_open);
    end
    $display("exit_priority: occupancy=%0d", occupancy);
  endtask

  task automatic test_car_under_barrier();
    sensor_exit = 1'b1;
    step();
    repeat (11) step();
    compared++;
    if (gate_open !== 1'b1 || occupancy !== 4'd1) begin
      mismatched++;
      $display("FAIL barrier_hold: gate=%b occ=%0d want 1 1", gate_open, occupancy);
    end
    sensor_exit = 1'b0;
    step();
    compared++;
    if (gate_open !== 1'b0 || occupancy !== 4'd0) begin
      mismatched++;
      $display("FAIL barrier_release: gate=%b occ=%0d want 0 0", gate_open, occupancy);
    end
    sensor_exit = 1'b1;
    step();
    sensor_exit = 1'b0;
    compared++;
    if (gate_open !== 1'b0 || occupancy !== 4'd0) begin
      mismatched++;
      $display("FAIL exit_when_empty: gate=%b occ=%0d want 0 0", gate_open, occupancy);
    end
    $display("car_under_barrier: occupancy=%0d", occupancy);
  endtask

  task automatic test_full();
    for (int c = 0; c < 8; c++) begin
      compared++;
      if (full !== 1'b0) begin
        mismatched++;
        $display("FAIL full_early%0d: full=%b want 0", c, full);
      end
      enter_car();
    end
    compared++;
    if (full !== 1'b1 || occupancy !== 4'd8) begin
      mismatched++;
      $display("FAIL full_reached: full=%b occ=%0d want 1 8", full, occupancy);
    end
    sensor_entrance = 1'b1;
    step();
    step();
    sensor_entrance = 1'b0;
    compared++;
    if (red_led !== 1'b0 || gate_open !== 1'b0 || occupancy !== 4'd8) begin
      mismatched++;
      $display("FAIL full_ignores_entry: red=%b gate=%b occ=%0d want 0 0 8", red_led, gate_open, occupancy);
    end
    $display("full: full=%b occupancy=%0d", full, occupancy);
  endtask

  task automatic test_reset_mid();
    sensor_exit = 1'b1;
    step();
    sensor_exit = 1'b0;
    repeat (8) step();
    compared++;
    if (occupancy !== 4'd7 || full !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_setup: occ=%0d full=%b want 7 0", occupancy, full);
    end
    sensor_entrance = 1'b1;
    step();
    sensor_entrance = 1'b0;
    password = GOOD;
    pass_valid = 1'b1;
    step();
    pass_valid = 1'b0;
    step();
    compared++;
    if (gate_open !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid_open: gate=%b want 1", gate_open);
    end
    #2 rst = 1'b0;
    #1;
    compared++;
    if (gate_open !== 1'b0 || green_led !== 1'b0 || occupancy !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_mid_async: gate=%b green=%b occ=%0d want 0 0 0", gate_open, green_led, occupancy);
    end
    step();
    rst = 1'b1;
    repeat (10) step();
    compared++;
    if (gate_open !== 1'b0 || occupancy !== 4'd0 || red_led !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_after: gate=%b red=%b occ=%0d want 0 0 0", gate_open, red_led, occupancy);
    end
    $display("reset_mid: gate=%b occupancy=%0d", gate_open, occupancy);
  endtask

  initial begin
    test_reset();
    test_good_entry();
    test_timeout();
    test_lockout();
    test_exit_priority();
    test_car_under_barrier();
    test_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
